// File: rtl/mem_stage_mc.sv
// Multi-channel memory stage between execute and writeback: decodes the effective
// address onto one of NCH req/ack slave channels, aligns stores, extends loads.
module mem_stage_mc #(
    parameter int unsigned         NCH        = 2,
    parameter logic [NCH*64-1:0]   CH_BASE    = {64'h0000_0000_0200_0000, 64'h0000_0000_8000_0000},
    parameter logic [NCH*64-1:0]   CH_MASK    = {64'h0000_0000_FF00_0000, 64'h0000_0000_FF00_0000},
    parameter logic [NCH-1:0]      CH_SKIPCMT = 2'b10,
    parameter int unsigned         TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_pc,
    input  logic [31:0]       in_inst,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_wen,
    input  logic [63:0]       in_rd_wdata,
    input  logic              in_ld,
    input  logic              in_st,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [63:0]       in_addr,
    input  logic [63:0]       in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic [4:0]        out_rd,
    output logic              out_rd_wen,
    output logic [63:0]       out_rd_wdata,
    output logic              out_skipcmt,
    output logic [1:0]        out_exc,
    output logic [NCH-1:0]    ch_req,
    output logic [63:0]       ch_addr,
    output logic              ch_wen,
    output logic [7:0]        ch_wstrb,
    output logic [63:0]       ch_wdata,
    input  logic [NCH-1:0]    ch_ack,
    input  logic [NCH*64-1:0] ch_rdata
);

    localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic              accept, is_mem, misaligned, any_hit, go_access;
    logic [SELW-1:0]   hit_sel, sel_q;
    logic [63:0]       pc_q, addr_q, wdata_q, res_q, rdata_sel;
    logic [31:0]       inst_q;
    logic [4:0]        rd_q;
    logic              st_q, uns_q, rd_wen_q, skip_q;
    logic [1:0]        size_q, exc_q;
    logic [CNTW-1:0]   cnt;
    logic              ack_sel, timeout_hit;
    logic [7:0]        strb_base;

    function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [2:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [63:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            2'd0:    load_extend = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'd1:    load_extend = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    load_extend = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: load_extend = sh;
        endcase
    endfunction

    // Address decode of the incoming instruction; lowest-index matching region wins.
    always_comb begin
        is_mem = in_ld | in_st;
        case (in_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = in_addr[0];
            2'd2:    misaligned = |in_addr[1:0];
            default: misaligned = |in_addr[2:0];
        endcase
        any_hit = 1'b0;
        hit_sel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!any_hit && ((in_addr & CH_MASK[64*i +: 64]) == CH_BASE[64*i +: 64])) begin
                any_hit = 1'b1;
                hit_sel = SELW'(i);
            end
        end
        go_access = is_mem & ~misaligned & any_hit;
    end

    assign ack_sel     = ch_ack[sel_q];
    assign rdata_sel   = ch_rdata[64*sel_q +: 64];
    // cnt counts ACCESS cycles already spent, so the request is held exactly TIMEOUT cycles.
    assign timeout_hit = (TIMEOUT != 0) && !ack_sel && ((32'(cnt) + 32'd1) == TIMEOUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        accept    = in_valid & in_ready;
        out_valid = (state == DONE);
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = go_access ? ACCESS : DONE;
            ACCESS:  if (ack_sel || timeout_hit) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = accept ? (go_access ? ACCESS : DONE) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
        ch_req   = '0;
        ch_addr  = '0;
        ch_wen   = 1'b0;
        ch_wstrb = '0;
        ch_wdata = '0;
        if (state == ACCESS) begin
            ch_req[sel_q] = 1'b1;
            ch_addr       = {addr_q[63:3], 3'b000};
            ch_wen        = st_q;
            ch_wstrb      = strb_base << addr_q[2:0];
            ch_wdata      = wdata_q << {addr_q[2:0], 3'b000};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= '0;
            inst_q   <= '0;
            rd_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            st_q     <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= '0;
            sel_q    <= '0;
            cnt      <= '0;
            res_q    <= '0;
            rd_wen_q <= 1'b0;
            exc_q    <= '0;
            skip_q   <= 1'b0;
        end else if (accept) begin
            pc_q    <= in_pc;
            inst_q  <= in_inst;
            rd_q    <= in_rd;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            st_q    <= in_st;
            uns_q   <= in_unsigned;
            size_q  <= in_size;
            sel_q   <= hit_sel;
            cnt     <= '0;
            skip_q  <= 1'b0;
            if (!is_mem) begin
                res_q    <= in_rd_wdata;
                rd_wen_q <= in_rd_wen;
                exc_q    <= 2'd0;
            end else begin
                res_q    <= '0;
                rd_wen_q <= go_access & in_rd_wen & ~in_st;
                exc_q    <= misaligned ? 2'd1 : (any_hit ? 2'd0 : 2'd2);
            end
        end else if (state == ACCESS) begin
            if (ack_sel) begin
                res_q  <= st_q ? '0 : load_extend(rdata_sel, addr_q[2:0], size_q, uns_q);
                skip_q <= CH_SKIPCMT[sel_q];
            end else if (timeout_hit) begin
                exc_q    <= 2'd3;
                rd_wen_q <= 1'b0;
            end else if (TIMEOUT != 0) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign out_pc       = pc_q;
    assign out_inst     = inst_q;
    assign out_rd       = rd_q;
    assign out_rd_wen   = rd_wen_q;
    assign out_rd_wdata = res_q;
    assign out_skipcmt  = skip_q;
    assign out_exc      = exc_q;

endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed, table-driven bench for mem_stage_mc with hand-written sequences for
// asynchronous reset during ACCESS and back-to-back issue.
module tb_mem_stage_mc;

    localparam int unsigned NCH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0, in_ready;
    logic [63:0]       in_pc = '0, in_rd_wdata = '0, in_addr = '0, in_wdata = '0;
    logic [31:0]       in_inst = '0;
    logic [4:0]        in_rd = '0;
    logic              in_rd_wen = 1'b0, in_ld = 1'b0, in_st = 1'b0, in_unsigned = 1'b0;
    logic [1:0]        in_size = '0;
    logic              out_valid, out_ready = 1'b0;
    logic [63:0]       out_pc, out_rd_wdata;
    logic [31:0]       out_inst;
    logic [4:0]        out_rd;
    logic              out_rd_wen, out_skipcmt;
    logic [1:0]        out_exc;
    logic [NCH-1:0]    ch_req;
    logic [63:0]       ch_addr, ch_wdata;
    logic              ch_wen;
    logic [7:0]        ch_wstrb;
    logic [NCH-1:0]    ch_ack = '0;
    logic [NCH*64-1:0] ch_rdata = '0;

    int n_vec  = 0;
    int n_miss = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    mem_stage_mc #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .in_rd_wdata(in_rd_wdata), .in_ld(in_ld), .in_st(in_st), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
        .out_rd_wdata(out_rd_wdata), .out_skipcmt(out_skipcmt), .out_exc(out_exc),
        .ch_req(ch_req), .ch_addr(ch_addr), .ch_wen(ch_wen), .ch_wstrb(ch_wstrb),
        .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_rdata(ch_rdata)
    );

    typedef struct {
        string       name;
        logic        ld, st;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr, wdata;
        logic        rdwen;
        logic [63:0] rdwd;
        logic [1:0]  ack_mask;
        int          dly;
        logic [63:0] rdata;
        logic [1:0]  e_req;
        logic [63:0] e_addr;
        logic [7:0]  e_strb;
        logic [63:0] e_wdata;
        logic        e_wen;
        logic [63:0] e_res;
        logic        e_rdwen;
        logic [1:0]  e_exc;
        logic        e_skip;
        int          e_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic ld, logic st, logic [1:0] size, logic uns,
                                logic [63:0] addr, logic [63:0] wdata, logic rdwen, logic [63:0] rdwd,
                                logic [1:0] ack_mask, int dly, logic [63:0] rdata,
                                logic [1:0] e_req, logic [63:0] e_addr, logic [7:0] e_strb,
                                logic [63:0] e_wdata, logic e_wen, logic [63:0] e_res,
                                logic e_rdwen, logic [1:0] e_exc, logic e_skip, int e_lat);
        vec_t v;
        v.name = name; v.ld = ld; v.st = st; v.size = size; v.uns = uns;
        v.addr = addr; v.wdata = wdata; v.rdwen = rdwen; v.rdwd = rdwd;
        v.ack_mask = ack_mask; v.dly = dly; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_strb = e_strb; v.e_wdata = e_wdata;
        v.e_wen = e_wen; v.e_res = e_res; v.e_rdwen = e_rdwen; v.e_exc = e_exc;
        v.e_skip = e_skip; v.e_lat = e_lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        int   acc;
        logic req_seen;
        logic done;
        @(negedge clk);
        chk({v.name, " in_ready"}, 64'(in_ready), 64'd1);
        in_pc       = 64'h1000 + 64'(idx * 4);
        in_inst     = 32'h13 + 32'(idx);
        in_rd       = 5'(idx + 1);
        in_rd_wen   = v.rdwen;
        in_rd_wdata = v.rdwd;
        in_ld       = v.ld;
        in_st       = v.st;
        in_size     = v.size;
        in_unsigned = v.uns;
        in_addr     = v.addr;
        in_wdata    = v.wdata;
        ch_ack      = '0;
        ch_rdata    = {~v.rdata, ~v.rdata};
        for (int c = 0; c < NCH; c++)
            if (v.ack_mask[c]) ch_rdata[64*c +: 64] = v.rdata;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; acc = 0; req_seen = 1'b0; done = 1'b0;
        while (!done && lat < 20) begin
            if (out_valid) begin
                done = 1'b1;
            end else begin
                if (ch_req != '0) begin
                    if (!req_seen) begin
                        chk({v.name, " ch_req"},   64'(ch_req),   64'(v.e_req));
                        chk({v.name, " ch_addr"},  ch_addr,       v.e_addr);
                        chk({v.name, " ch_wstrb"}, 64'(ch_wstrb), 64'(v.e_strb));
                        chk({v.name, " ch_wdata"}, ch_wdata,      v.e_wdata);
                        chk({v.name, " ch_wen"},   64'(ch_wen),   64'(v.e_wen));
                    end
                    req_seen = 1'b1;
                    if (acc == v.dly) ch_ack = v.ack_mask;
                    acc++;
                end
                @(posedge clk);
                @(negedge clk);
                lat++;
            end
        end
        ch_ack = '0;
        n_chk++;
        if (!done) begin
            n_miss++;
            $display("FAIL %s out_valid: got 0 expected 1 within 20 cycles", v.name);
        end
        chk({v.name, " latency"},  64'(lat),          64'(v.e_lat));
        chk({v.name, " req_seen"}, 64'(req_seen),     64'(v.e_req != '0));
        chk({v.name, " rd_wdata"}, out_rd_wdata,      v.e_res);
        chk({v.name, " rd_wen"},   64'(out_rd_wen),   64'(v.e_rdwen));
        chk({v.name, " exc"},      64'(out_exc),      64'(v.e_exc));
        chk({v.name, " skipcmt"},  64'(out_skipcmt),  64'(v.e_skip));
        chk({v.name, " pc"},       out_pc,            64'h1000 + 64'(idx * 4));
        chk({v.name, " rd"},       64'(out_rd),       64'(idx + 1));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({v.name, " drained"},  64'(out_valid),    64'd0);
        n_vec++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        //       name          ld st sz u  addr                    wdata                   rdw rdwd                    ack   dly rdata
        //       e_req e_addr                  strb   e_wdata                 wen e_res                   erw exc skp lat
        vecs.push_back(mk("lw_ch0",      1, 0, 2, 0, 64'h8000_0004, 64'h0, 1, 64'h0, 2'b01, 2, 64'h8765_4321_0000_0000,
                          2'b01, 64'h8000_0000, 8'hF0, 64'h0, 0, 64'hFFFF_FFFF_8765_4321, 1, 0, 0, 4));
        vecs.push_back(mk("sb_ch0",      0, 1, 0, 0, 64'h8000_0003, 64'hAB, 0, 64'h0, 2'b01, 0, 64'h0,
                          2'b01, 64'h8000_0000, 8'h08, 64'hAB00_0000, 1, 64'h0, 0, 0, 0, 2));
        vecs.push_back(mk("ld_clint",    1, 0, 3, 0, 64'h0200_BFF8, 64'h0, 1, 64'h0, 2'b10, 0, 64'h1234,
                          2'b10, 64'h0200_BFF8, 8'hFF, 64'h0, 0, 64'h1234, 1, 0, 1, 2));
        vecs.push_back(mk("lh_misal",    1, 0, 1, 0, 64'h8000_0001, 64'h0, 1, 64'h0, 2'b00, 99, 64'h0,
                          2'b00, 64'h0, 8'h00, 64'h0, 0, 64'h0, 0, 1, 0, 1));
        vecs.push_back(mk("ld_fault",    1, 0, 3, 0, 64'h4000_0000, 64'h0, 1, 64'h0, 2'b00, 99, 64'h0,
                          2'b00, 64'h0, 8'h00, 64'h0, 0, 64'h0, 0, 2, 0, 1));
        vecs.push_back(mk("sh_misal",    0, 1, 1, 0, 64'h8000_0003, 64'hBEEF, 0, 64'h0, 2'b00, 99, 64'h0,
                          2'b00, 64'h0, 8'h00, 64'h0, 0, 64'h0, 0, 1, 0, 1));
        vecs.push_back(mk("alu_pass",    0, 0, 3, 0, 64'h8000_0001, 64'h0, 1, 64'hDEAD_BEEF_0123_4567, 2'b00, 99, 64'h0,
                          2'b00, 64'h0, 8'h00, 64'h0, 0, 64'hDEAD_BEEF_0123_4567, 1, 0, 0, 1));
        vecs.push_back(mk("lbu_b5",      1, 0, 0, 1, 64'h8000_0005, 64'h0, 1, 64'h0, 2'b01, 1, 64'h0000_F000_0000_0000,
                          2'b01, 64'h8000_0000, 8'h20, 64'h0, 0, 64'h0000_0000_0000_00F0, 1, 0, 0, 3));
        vecs.push_back(mk("lb_b5",       1, 0, 0, 0, 64'h8000_0005, 64'h0, 1, 64'h0, 2'b01, 1, 64'h0000_F000_0000_0000,
                          2'b01, 64'h8000_0000, 8'h20, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 1, 0, 0, 3));
        vecs.push_back(mk("lh_lastcyc",  1, 0, 1, 0, 64'h8000_0006, 64'h0, 1, 64'h0, 2'b01, 3, 64'h8001_0000_0000_0000,
                          2'b01, 64'h8000_0000, 8'hC0, 64'h0, 0, 64'hFFFF_FFFF_FFFF_8001, 1, 0, 0, 5));
        vecs.push_back(mk("sd_ch0",      0, 1, 3, 0, 64'h8000_0010, 64'h1122_3344_5566_7788, 0, 64'h0, 2'b01, 1, 64'h0,
                          2'b01, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 1, 64'h0, 0, 0, 0, 3));
        vecs.push_back(mk("lw_timeout",  1, 0, 2, 0, 64'h8000_0008, 64'h0, 1, 64'h0, 2'b00, 99, 64'h0,
                          2'b01, 64'h8000_0008, 8'h0F, 64'h0, 0, 64'h0, 0, 3, 0, 5));
        vecs.push_back(mk("wrong_ack",   1, 0, 2, 0, 64'h0200_0000, 64'h0, 1, 64'h0, 2'b01, 0, 64'h5555,
                          2'b10, 64'h0200_0000, 8'h0F, 64'h0, 0, 64'h0, 0, 3, 0, 5));
        vecs.push_back(mk("lwu_clint",   1, 0, 2, 1, 64'h0200_0004, 64'h0, 1, 64'h0, 2'b10, 0, 64'hFEDC_BA98_0000_0000,
                          2'b10, 64'h0200_0000, 8'hF0, 64'h0, 0, 64'h0000_0000_FEDC_BA98, 1, 0, 1, 2));
        vecs.push_back(mk("sw_clint",    0, 1, 2, 0, 64'h0200_0008, 64'hCAFE_F00D, 0, 64'h0, 2'b10, 0, 64'h0,
                          2'b10, 64'h0200_0008, 8'h0F, 64'h0000_0000_CAFE_F00D, 1, 64'h0, 0, 0, 1, 2));

        #1 rst = 1'b0;
        #11;
        chk("reset in_ready",  64'(in_ready),  64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset ch_req",    64'(ch_req),    64'd0);
        chk("reset out_exc",   64'(out_exc),   64'd0);
        chk("reset rd_wdata",  out_rd_wdata,   64'd0);
        chk("reset ch_wstrb",  64'(ch_wstrb),  64'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset asserted between edges while a request is outstanding.
        @(negedge clk);
        in_ld = 1'b1; in_st = 1'b0; in_size = 2'd2; in_unsigned = 1'b0;
        in_addr = 64'h8000_0000; in_rd_wen = 1'b1; ch_ack = '0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_mid pre ch_req", 64'(ch_req), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid async ch_req",   64'(ch_req),    64'd0);
        chk("rst_mid async in_ready", 64'(in_ready),  64'd1);
        chk("rst_mid async out_valid",64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid after in_ready", 64'(in_ready),  64'd1);
        chk("rst_mid after ch_req",   64'(ch_req),    64'd0);
        chk("rst_mid after out_valid",64'(out_valid), 64'd0);
        n_vec++;

        // ALU op followed immediately by LBU with out_ready held high.
        @(negedge clk);
        in_ld = 1'b0; in_st = 1'b0; in_size = 2'd3; in_unsigned = 1'b0;
        in_addr = 64'h0; in_rd_wdata = 64'h55AA; in_rd_wen = 1'b1; in_pc = 64'h2000; in_rd = 5'd7;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b add out_valid", 64'(out_valid), 64'd1);
        chk("b2b add rd_wdata",  out_rd_wdata,   64'h55AA);
        chk("b2b add pc",        out_pc,         64'h2000);
        chk("b2b add in_ready",  64'(in_ready),  64'd1);
        in_ld = 1'b1; in_size = 2'd0; in_unsigned = 1'b1; in_addr = 64'h8000_0000;
        in_pc = 64'h2004; in_rd = 5'd8;
        ch_rdata = {64'hFFFF_FFFF_FFFF_FFFF, 64'h1122_3344_5566_77F0};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b lbu no bubble ch_req", 64'(ch_req),    64'd1);
        chk("b2b lbu out_valid low",    64'(out_valid), 64'd0);
        ch_ack = 2'b01;
        @(posedge clk);
        @(negedge clk);
        ch_ack = '0;
        chk("b2b lbu out_valid", 64'(out_valid), 64'd1);
        chk("b2b lbu rd_wdata",  out_rd_wdata,   64'h0000_0000_0000_00F0);
        chk("b2b lbu pc",        out_pc,         64'h2004);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b idle out_valid", 64'(out_valid), 64'd0);
        chk("b2b idle in_ready",  64'(in_ready),  64'd1);
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_stage_mc.md
Name: mem_stage_mc

Overview:
- Parametrised successor of the single-path memory stage, sitting between the execute and writeback stages.
- Accepts one executed instruction at a time and decodes its effective address against NCH configurable address regions.
- Drives a req/ack access on the selected region channel: DCache, CLINT/MMIO, or future slaves.
- Performs byte-lane store alignment and load extraction with sign/zero extension. Adds misalignment, access-fault and timeout exceptions, which the previous block lacked.

Parameters:
- NCH, 2: number of slave channels/regions (1..8).
- CH_BASE, {64'h0200_0000, 64'h8000_0000}: packed NCH x 64 region base addresses; channel i occupies bits [64i+63:64i].
- CH_MASK, {64'hFF00_0000, 64'hFF00_0000}: packed NCH x 64 region masks. A hit on channel i means (addr & mask_i) == base_i.
- CH_SKIPCMT, 2'b10: per-channel flag; a set bit makes out_skipcmt=1 for accesses on that channel (MMIO, excluded from difftest).
- TIMEOUT, 255: maximum cycles spent in ACCESS before abort. A value of 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  executed instruction valid.
- in_ready  out  1  stage can accept.
- in_pc / in_inst  in  64 / 32  passed through.
- in_rd / in_rd_wen / in_rd_wdata  in  5 / 1 / 64  writeback info; in_rd_wdata is used for non-memory ops.
- in_ld / in_st  in  1 / 1  load / store; asserting both is illegal.
- in_size  in  2  0=B, 1=H, 2=W, 3=D.
- in_unsigned  in  1  zero-extend the load.
- in_addr  in  64  effective address.
- in_wdata  in  64  store data, right-aligned.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_pc / out_inst / out_rd / out_rd_wen  out  64 / 32 / 5 / 1  registered passthrough.
- out_rd_wdata  out  64  load result, or in_rd_wdata for non-memory ops.
- out_skipcmt  out  1  skip commit compare.
- out_exc  out  2  0 none, 1 misaligned, 2 access fault, 3 timeout.
- ch_req  out  NCH  one-hot request, held until ack.
- ch_addr  out  64  {addr[63:3],3'b0}.
- ch_wen  out  1  1 = write.
- ch_wstrb  out  8  byte strobes.
- ch_wdata  out  64  lane-shifted store data.
- ch_ack  in  NCH  per-channel completion.
- ch_rdata  in  NCH*64  per-channel 64-bit-aligned read data, valid with ack.

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset (rst=0, asynchronous) forces IDLE.
  - Outputs go to in_ready=1, out_valid=0, ch_req=0, out_exc=0.
  - All data outputs and registers go to 0.
  - Reset in ACCESS drops ch_req immediately; slaves must tolerate an abandoned request.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept means in_valid & in_ready; all in_* are registered on accept.
- On accept:
  - Non-memory op (in_ld=in_st=0): go to DONE with out_rd_wdata=in_rd_wdata. Latency is 1 cycle.
  - Misaligned access (addr mod 2^size != 0): go to DONE with exc=1, rd_wen forced to 0, no ch_req.
  - No region hit: go to DONE with exc=2, rd_wen=0.
  - Otherwise: go to ACCESS with sel = lowest-index hit channel.
- ACCESS:
  - ch_req[sel]=1 and all ch_* outputs are stable until ack.
  - ch_wstrb = ((1<<(1<<size))-1) << addr[2:0].
  - ch_wdata = wdata << 8*addr[2:0].
  - When ch_ack[sel]=1, including in the first ACCESS cycle:
    - Load: out_rd_wdata = extend((ch_rdata[sel] >> 8*addr[2:0]) truncated to size).
    - Store: out_rd_wdata = 0.
    - Then go to DONE.
  - Acks on unselected channels are ignored.
  - The timeout counter clears on entry and increments each ACCESS cycle. If it equals TIMEOUT with no ack, drop req and go to DONE with exc=3, rd_wen=0.
- DONE:
  - out_valid=1 and outputs are held until out_ready.
  - out_ready with no new accept: return to IDLE.
  - out_ready with a simultaneous accept: process the new instruction as if from IDLE (back-to-back, no bubble).
- out_skipcmt = CH_SKIPCMT[sel] for a completed access, else 0.
- Minimum load latency: accept -> ACCESS (ack same cycle) -> DONE, i.e. out_valid 2 cycles after accept.

Test Plan:
- LW addr 0x8000_0004, ch0 acks in 3 cycles with rdata 0x8765_4321_0000_0000 -> ch_addr 0x8000_0000, ch_req=01; out_rd_wdata 0xFFFF_FFFF_8765_4321, exc=0, skipcmt=0.
- SB addr 0x8000_0003, wdata 0xAB -> ch_wstrb 0x08, ch_wdata 0x0000_0000_AB00_0000, ch_wen=1; out_rd_wen=0 on completion.
- LD addr 0x0200_BFF8, ch1 rdata 0x1234 acked immediately -> ch_req=10; out_valid 2 cycles after accept; out_rd_wdata 0x1234, out_skipcmt=1.
- LH addr 0x8000_0001 -> no ch_req, exc=1. LD addr 0x4000_0000 -> exc=2. Neither writes rd.
- TIMEOUT=4, ch0 never acks -> ch_req drops after 4 ACCESS cycles, exc=3. Reset asserted mid-ACCESS -> ch_req=0 asynchronously and in_ready=1 after release.
- Back-to-back ADD then LBU with out_ready held at 1 -> no idle cycle between them. LBU of byte 0xF0 -> out_rd_wdata 0xF0.
